// File: rtl/hub75_pixel_fetch.sv
// hub75_pixel_fetch
//   Walks the framebuffer in HUB75 scan order (row outer, bit-plane inner,
//   column innermost), reads the top-half and bottom-half pixel of each
//   column and presents the current bit-plane as {r1,g1,b1,r2,g2,b2} on a
//   valid/ready stream feeding the panel shifter/latch driver.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   enable           run scan; only looked at in IDLE and on the last transfer of a frame
//   fb_addr, fb_re   framebuffer read port, address {half,row,col}; half 1 = bottom
//   fb_rdata         read data, one cycle after fb_re; {R,G,B} each BPC bits
//   pix_valid/ready  output stream handshake
//   pix_rgb          {r1,g1,b1,r2,g2,b2} for the current plane
//   pix_row/plane    scan position of the presented column
//   pix_last         presented column is the last of its row-plane
//   frame_done       one-cycle pulse after the final transfer of a frame
module hub75_pixel_fetch #(
    parameter int ROWS = 8,
    parameter int COLS = 32,
    parameter int BPC  = 4,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS),
    parameter int PW   = $clog2(BPC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [RW+CW:0]    fb_addr,
    output logic              fb_re,
    input  logic [3*BPC-1:0]  fb_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [5:0]        pix_rgb,
    output logic [RW-1:0]     pix_row,
    output logic [PW-1:0]     pix_plane,
    output logic              pix_last,
    output logic              frame_done
);

    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [PW-1:0] PLANE_MAX = PW'(BPC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_TOP,
        ADDR_BOT,
        CAPTURE,
        PRESENT
    } state_t;

    state_t            state;
    logic [RW-1:0]     row;
    logic [PW-1:0]     plane;
    logic [CW-1:0]     col;
    logic [3*BPC-1:0]  top_q;

    logic              col_last;
    logic              plane_last;
    logic              frame_end;
    logic [RW-1:0]     row_nx;
    logic [PW-1:0]     plane_nx;
    logic [CW-1:0]     col_nx;

    function automatic logic [2:0] slice(input logic [3*BPC-1:0] px, input logic [PW-1:0] p);
        logic [BPC-1:0] r, g, b;
        r = px[3*BPC-1:2*BPC];
        g = px[2*BPC-1:BPC];
        b = px[BPC-1:0];
        return {r[p], g[p], b[p]};
    endfunction

    // Scan position after the current column is accepted.
    always_comb begin
        col_last   = (col == COL_MAX);
        plane_last = (plane == PLANE_MAX);
        frame_end  = col_last && plane_last && (row == ROW_MAX);
        col_nx     = col_last ? '0 : col + 1'b1;
        plane_nx   = plane;
        row_nx     = row;
        if (col_last) begin
            plane_nx = plane_last ? '0 : plane + 1'b1;
            if (plane_last) begin
                row_nx = (row == ROW_MAX) ? '0 : row + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            plane      <= '0;
            col        <= '0;
            top_q      <= '0;
            fb_addr    <= '0;
            fb_re      <= 1'b0;
            pix_valid  <= 1'b0;
            pix_rgb    <= '0;
            pix_row    <= '0;
            pix_plane  <= '0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= ADDR_TOP;
                        fb_re   <= 1'b1;
                        fb_addr <= {1'b0, row, col};
                    end
                end
                ADDR_TOP: begin
                    state   <= ADDR_BOT;
                    fb_re   <= 1'b1;
                    fb_addr <= {1'b1, row, col};
                end
                ADDR_BOT: begin
                    state   <= CAPTURE;
                    top_q   <= fb_rdata;
                    fb_re   <= 1'b0;
                    fb_addr <= '0;
                end
                CAPTURE: begin
                    // Bottom pixel is only needed for its plane bits, so
                    // those are registered straight into pix_rgb.
                    state     <= PRESENT;
                    pix_valid <= 1'b1;
                    pix_rgb   <= {slice(top_q, plane), slice(fb_rdata, plane)};
                    pix_row   <= row;
                    pix_plane <= plane;
                    pix_last  <= col_last;
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid  <= 1'b0;
                        row        <= row_nx;
                        plane      <= plane_nx;
                        col        <= col_nx;
                        frame_done <= frame_end;
                        if (frame_end && !enable) begin
                            state <= IDLE;
                        end else begin
                            state   <= ADDR_TOP;
                            fb_re   <= 1'b1;
                            fb_addr <= {1'b0, row_nx, col_nx};
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    fb_re     <= 1'b0;
                    fb_addr   <= '0;
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
